// File: rtl/deser_param.sv
// deser_param: serial-to-parallel deserializer with flush, backed by one held word behind the output register
module deser_param #(
  parameter int DATA_W = 16,
  parameter int MSB_FIRST = 1,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]  deser_data_len_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i
);
  logic [DATA_W-1:0] asm_q, asm_d, asm_b, out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_b, plen_q, plen_d, olen_q, olen_d, pos;
  logic oval_q, oval_d, acc, free, done, mv;
  always_comb begin
    data_ready_o = cnt_q != CNT_W'(DATA_W);
    acc = data_val_i && data_ready_o;
    free = !oval_q || deser_data_ready_i;
    pos = (MSB_FIRST != 0) ? CNT_W'(DATA_W - 1) - cnt_q : cnt_q;
    asm_b = asm_q | (DATA_W'(acc && data_i) << pos);
    cnt_b = cnt_q + CNT_W'(acc);
    done = data_ready_o && (cnt_b == CNT_W'(DATA_W) || (flush_i && cnt_b != '0));
    mv = free && (!data_ready_o || done);
    out_d = mv ? (data_ready_o ? asm_b : asm_q) : out_q;
    olen_d = mv ? (data_ready_o ? cnt_b : plen_q) : olen_q;
    oval_d = mv || (oval_q && !deser_data_ready_i);
    asm_d = mv ? '0 : asm_b;
    cnt_d = mv ? '0 : (done ? CNT_W'(DATA_W) : cnt_b);
    plen_d = (done && !mv) ? cnt_b : plen_q;
  end
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      asm_q <= '0;
      cnt_q <= '0;
      plen_q <= '0;
      out_q <= '0;
      olen_q <= '0;
      oval_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
      plen_q <= plen_d;
      out_q <= out_d;
      olen_q <= olen_d;
      oval_q <= oval_d;
    end
  end
  assign deser_data_o = out_q;
  assign deser_data_len_o = olen_q;
  assign deser_data_val_o = oval_q;
endmodule

// File: tb/tb_deser_param.sv
// tb_deser_param: directed and randomized checks of deser_param against a word-queue reference model
module tb_deser_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic d0 = 0, v0 = 0, f0 = 0, r0 = 0, rdy0, val0;
  logic [15:0] q0;
  logic [4:0] l0;
  logic d1 = 0, v1 = 0, f1 = 0, r1 = 0, rdy1, val1;
  logic [7:0] q1;
  logic [3:0] l1;
  int checks = 0, failures = 0;

  deser_param #(.DATA_W(16), .MSB_FIRST(1)) u0 (
    .clk_i(clk), .srst_n_i(rst_n), .data_i(d0), .data_val_i(v0), .data_ready_o(rdy0),
    .flush_i(f0), .deser_data_o(q0), .deser_data_len_o(l0), .deser_data_val_o(val0),
    .deser_data_ready_i(r0)
  );
  deser_param #(.DATA_W(8), .MSB_FIRST(0)) u1 (
    .clk_i(clk), .srst_n_i(rst_n), .data_i(d1), .data_val_i(v1), .data_ready_o(rdy1),
    .flush_i(f1), .deser_data_o(q1), .deser_data_len_o(l1), .deser_data_val_o(val1),
    .deser_data_ready_i(r1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; v0 = 1; d0 = 1; f0 = 1; r0 = 0; v1 = 1; d1 = 1; f1 = 1; r1 = 0;
    tick; tick;
    checks++;
    if ({rdy0, val0, l0, q0} !== {1'b1, 1'b0, 5'd0, 16'd0}) begin
      failures++; $display("FAIL reset_u0 got=%h exp=%h", {rdy0, val0, l0, q0}, {1'b1, 1'b0, 5'd0, 16'd0});
    end
    checks++;
    if ({rdy1, val1, l1, q1} !== {1'b1, 1'b0, 4'd0, 8'd0}) begin
      failures++; $display("FAIL reset_u1 got=%h exp=%h", {rdy1, val1, l1, q1}, {1'b1, 1'b0, 4'd0, 8'd0});
    end
    rst_n = 1; v0 = 0; d0 = 0; f0 = 0; r0 = 1; v1 = 0; d1 = 0; f1 = 0; r1 = 1;
    tick;
    checks++;
    if ({rdy0, val0, rdy1, val1} !== 4'b1010) begin
      failures++; $display("FAIL reset_release got=%b exp=1010", {rdy0, val0, rdy1, val1});
    end
  endtask

  task automatic test_msb_word;
    logic [15:0] w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      d0 = w[15-i]; v0 = 1;
      tick;
      if (i < 15) begin
        checks++;
        if (val0 !== 1'b0) begin failures++; $display("FAIL msb_early_val bit=%0d got=%b exp=0", i, val0); end
      end
    end
    v0 = 0;
    checks++;
    if ({val0, l0, q0} !== {1'b1, 5'd16, w}) begin
      failures++; $display("FAIL msb_word got=%h exp=%h", {val0, l0, q0}, {1'b1, 5'd16, w});
    end
    tick;
    checks++;
    if (val0 !== 1'b0) begin failures++; $display("FAIL msb_val_pulse got=%b exp=0", val0); end
  endtask

  task automatic test_lsb_flush;
    logic [3:0] b = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      d1 = b[i]; v1 = 1;
      tick;
    end
    v1 = 0; f1 = 1;
    tick;
    f1 = 0;
    checks++;
    if ({val1, l1, q1} !== {1'b1, 4'd4, 8'h0D}) begin
      failures++; $display("FAIL lsb_flush got=%h exp=%h", {val1, l1, q1}, {1'b1, 4'd4, 8'h0D});
    end
    tick;
    checks++;
    if (val1 !== 1'b0) begin failures++; $display("FAIL lsb_flush_pulse got=%b exp=0", val1); end
  endtask

  task automatic test_flush_edge;
    f0 = 1; v0 = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (val0 !== 1'b0) begin failures++; $display("FAIL empty_flush got=%b exp=0", val0); end
    end
    f0 = 0; d0 = 1; v0 = 1;
    tick;
    d0 = 0;
    tick;
    d0 = 1; f0 = 1;
    tick;
    v0 = 0; f0 = 0;
    checks++;
    if ({val0, l0, q0} !== {1'b1, 5'd3, 16'hA000}) begin
      failures++; $display("FAIL flush_with_bit got=%h exp=%h", {val0, l0, q0}, {1'b1, 5'd3, 16'hA000});
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [7:0] a = 8'($urandom), b = 8'($urandom);
    r1 = 0;
    for (int i = 0; i < 16; i++) begin
      d1 = (i < 8) ? a[i] : b[i-8]; v1 = 1;
      tick;
      if (i == 7) begin
        checks++;
        if ({val1, l1, q1, rdy1} !== {1'b1, 4'd8, a, 1'b1}) begin
          failures++; $display("FAIL bp_first got=%h exp=%h", {val1, l1, q1, rdy1}, {1'b1, 4'd8, a, 1'b1});
        end
      end
    end
    checks++;
    if ({rdy1, val1, q1} !== {1'b0, 1'b1, a}) begin
      failures++; $display("FAIL bp_full got=%h exp=%h", {rdy1, val1, q1}, {1'b0, 1'b1, a});
    end
    d1 = 1;
    tick; tick; tick;
    checks++;
    if ({rdy1, val1, l1, q1} !== {1'b0, 1'b1, 4'd8, a}) begin
      failures++; $display("FAIL bp_hold got=%h exp=%h", {rdy1, val1, l1, q1}, {1'b0, 1'b1, 4'd8, a});
    end
    v1 = 0; r1 = 1;
    tick;
    checks++;
    if ({val1, l1, q1, rdy1} !== {1'b1, 4'd8, b, 1'b1}) begin
      failures++; $display("FAIL bp_second got=%h exp=%h", {val1, l1, q1, rdy1}, {1'b1, 4'd8, b, 1'b1});
    end
    tick;
    checks++;
    if (val1 !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", val1); end
    f1 = 1;
    tick;
    f1 = 0;
    checks++;
    if (val1 !== 1'b0) begin failures++; $display("FAIL bp_no_leak got=%b exp=0", val1); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w = 16'($urandom);
    r0 = 1; r1 = 0;
    for (int i = 0; i < 11; i++) begin
      v1 = 1; d1 = 1'($urandom_range(0, 1));
      v0 = (i < 7); d0 = 1'($urandom_range(0, 1));
      tick;
    end
    v0 = 0; v1 = 0; rst_n = 0;
    tick;
    rst_n = 1; r1 = 1;
    for (int i = 0; i < 16; i++) begin
      d0 = w[15-i]; v0 = 1;
      tick;
      if (i < 15) begin
        checks++;
        if ({val0, val1} !== 2'b00) begin failures++; $display("FAIL rst_mid_early bit=%0d got=%b exp=00", i, {val0, val1}); end
      end
    end
    v0 = 0;
    checks++;
    if ({val0, l0, q0} !== {1'b1, 5'd16, w}) begin
      failures++; $display("FAIL rst_mid_word got=%h exp=%h", {val0, l0, q0}, {1'b1, 5'd16, w});
    end
    f1 = 1;
    tick;
    f1 = 0;
    checks++;
    if ({val0, val1} !== 2'b00) begin failures++; $display("FAIL rst_mid_after got=%b exp=00", {val0, val1}); end
  endtask

  task automatic test_random;
    logic bits[$];
    logic [15:0] wq[$];
    logic [4:0] lq[$];
    logic [15:0] w;
    logic exp_rdy, cons;
    int words = 0;
    rst_n = 0;
    tick;
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      v0 = $urandom_range(0, 3) != 0;
      d0 = 1'($urandom_range(0, 1));
      f0 = $urandom_range(0, 9) == 0;
      r0 = (c % 200 < 40) ? 1'b0 : ($urandom_range(0, 2) != 0);
      exp_rdy = wq.size() < 2;
      checks++;
      if (rdy0 !== exp_rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, rdy0, exp_rdy); end
      cons = wq.size() > 0 && r0;
      if (exp_rdy) begin
        if (v0) bits.push_back(d0);
        if (bits.size() == 16 || (f0 && bits.size() > 0)) begin
          w = '0;
          foreach (bits[k]) w[15-k] = bits[k];
          wq.push_back(w);
          lq.push_back(5'(bits.size()));
          bits.delete();
          words++;
        end
      end
      if (cons) begin
        void'(wq.pop_front());
        void'(lq.pop_front());
      end
      tick;
      checks++;
      if (val0 !== (wq.size() > 0)) begin
        failures++; $display("FAIL rand_val cyc=%0d got=%b exp=%b", c, val0, wq.size() > 0);
      end else if (wq.size() > 0) begin
        checks++;
        if ({l0, q0} !== {lq[0], wq[0]}) begin
          failures++; $display("FAIL rand_word cyc=%0d got=%h exp=%h", c, {l0, q0}, {lq[0], wq[0]});
        end
      end
    end
    checks++;
    if (words < 50) begin failures++; $display("FAIL rand_activity words=%0d exp>=50", words); end
    v0 = 0; f0 = 0; r0 = 1;
  endtask

  initial begin
    test_reset;
    test_msb_word;
    test_lsb_flush;
    test_flush_edge;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
